// File: rtl/measurement_pkg.sv
// Shared state encoding, default widths and count-mode constants for the measurement window counter.
package measurement_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int CNT_W_DEF = 12;
  localparam int WIN_W_DEF = 16;

  localparam bit MODE_WRAP     = 1'b0;
  localparam bit MODE_SATURATE = 1'b1;

endpackage

// File: rtl/measurement_channel_acc.sv
// One channel accumulator with sticky overflow; exposes its next value so the final sample can be latched same-edge.
// Single-cycle update, no backpressure: clear takes priority over enable.
module measurement_channel_acc
  import measurement_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit SATURATE = MODE_SATURATE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             ovf_nxt_o
);

  logic [CNT_W-1:0] acc_q;
  logic             ovf_q;

  always_comb begin
    cnt_nxt_o = acc_q;
    ovf_nxt_o = ovf_q;
    if (en_i) begin
      if (acc_q == '1) begin
        ovf_nxt_o = 1'b1;
        if (SATURATE == MODE_WRAP) cnt_nxt_o = '0;
      end else begin
        cnt_nxt_o = acc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= cnt_nxt_o;
      ovf_q <= ovf_nxt_o;
    end
  end

endmodule

// File: rtl/measurement_window_counter.sv
// Multi-channel windowed event counter; result valid exactly L edges after the start edge.
// Result offered on valid/ready; an unconsumed result is overwritten by the next one and flagged via overrun_o.
module measurement_window_counter
  import measurement_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WIN_W    = WIN_W_DEF,
  parameter bit SATURATE = MODE_SATURATE
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    continuous_i,
  input  logic                    abort_i,
  input  logic [WIN_W-1:0]        window_len_i,
  input  logic [NUM_CH-1:0]       measurement_en_i,
  input  logic                    result_ready_i,
  output logic                    result_valid_o,
  output logic [NUM_CH*CNT_W-1:0] result_count_o,
  output logic [NUM_CH-1:0]       result_ovf_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  state_e                    state_q, state_d;
  logic [WIN_W-1:0]          rem_q, rem_d, len_q, len_d;
  logic [NUM_CH*CNT_W-1:0]   res_cnt_q, res_cnt_d, acc_nxt;
  logic [NUM_CH-1:0]         res_ovf_q, res_ovf_d, ovf_nxt, acc_en;
  logic                      res_vld_q, res_vld_d, overrun_q, overrun_d;
  logic                      counting, start_go, last_cycle, load, acc_clr;

  assign counting   = (state_q == ST_COUNT);
  assign start_go   = !counting && start_i && (window_len_i != '0);
  assign last_cycle = counting && (rem_q == WIN_W'(1));
  assign load       = last_cycle && !abort_i;
  // Accumulators restart at every window boundary so continuous windows lose no sample.
  assign acc_clr    = start_go || (counting && abort_i) || last_cycle;
  assign acc_en     = counting ? measurement_en_i : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    measurement_channel_acc #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_acc (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (acc_clr),
      .en_i      (acc_en[k]),
      .cnt_nxt_o (acc_nxt[k*CNT_W +: CNT_W]),
      .ovf_nxt_o (ovf_nxt[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_d     = len_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    res_vld_d = res_vld_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d   = ST_COUNT;
          rem_d     = window_len_i;
          len_d     = window_len_i;
          overrun_d = 1'b0;
        end
      end
      ST_COUNT: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (last_cycle) begin
          if (continuous_i) begin
            rem_d = len_q;
          end else begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      res_cnt_d = acc_nxt;
      res_ovf_d = ovf_nxt;
      res_vld_d = 1'b1;
      if (res_vld_q && !result_ready_i) overrun_d = 1'b1;
    end else if (res_vld_q && result_ready_i) begin
      res_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      len_q     <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= '0;
      res_vld_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
      res_vld_q <= res_vld_d;
      overrun_q <= overrun_d;
    end
  end

  assign result_valid_o = res_vld_q;
  assign result_count_o = res_cnt_q;
  assign result_ovf_o   = res_ovf_q;
  assign busy_o         = counting;
  assign overrun_o      = overrun_q;

endmodule
